// File: rtl/an_decode_rr_sched.sv
// an_decode_rr_sched
//
// Two-channel round-robin front end for a single A=13 AN-code decoder. Each
// channel offers 6-bit codewords on a valid/ready handshake. One codeword per
// cycle is granted into a two-stage pipeline:
//   S1 : registers the granted codeword and its channel tag
//   S2 : Barrett-style reduction into quotient/remainder output registers
// Per-channel saturating counters record how many erroneous (r != 0) results
// have been transferred downstream.
//
// Ports
//   clk, rst                  clock (rising edge), async active-high reset
//   in0_valid/in0_codeword    channel 0 request and codeword
//   in0_ready                 channel 0 codeword accepted this cycle
//   in1_valid/in1_codeword    channel 1 request and codeword
//   in1_ready                 channel 1 codeword accepted this cycle
//   out_valid/out_ready       result handshake
//   out_ch                    channel the result came from
//   out_q, out_r              codeword div 13, codeword mod 13
//   out_error                 out_r != 0
//   clr_cnt                   synchronous clear of both error counters
//   err_cnt0, err_cnt1        saturating error counts per channel

module an_decode_rr_sched #(
  parameter int unsigned CW_W  = 6,
  parameter int unsigned CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in0_valid,
  input  logic [CW_W-1:0]  in0_codeword,
  output logic             in0_ready,
  input  logic             in1_valid,
  input  logic [CW_W-1:0]  in1_codeword,
  output logic             in1_ready,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             out_ch,
  output logic [2:0]       out_q,
  output logic [3:0]       out_r,
  output logic             out_error,
  input  logic             clr_cnt,
  output logic [CNT_W-1:0] err_cnt0,
  output logic [CNT_W-1:0] err_cnt1
);

  // ---------------------------------------------------------------------------
  // Pipeline enable and arbitration
  // ---------------------------------------------------------------------------
  logic en;
  logic any_req;
  logic grant1;      // granted channel when any_req (0 or 1)
  logic do_grant;
  logic prio_q, prio_d;

  logic            s1_valid_q;
  logic            s1_ch_q;
  logic [CW_W-1:0] s1_cw_q;

  // The whole pipeline advances together; a stalled output freezes S1 too.
  assign en = !out_valid || out_ready;

  always_comb begin
    any_req = in0_valid || in1_valid;
    // Channel 1 wins if it is the only requester, or on a tie when prio points at it.
    grant1   = in1_valid && (!in0_valid || prio_q);
    do_grant = en && any_req;
    prio_d   = prio_q;
    if (do_grant) begin
      prio_d = !grant1;
    end
  end

  assign in0_ready = do_grant && !grant1;
  assign in1_ready = do_grant && grant1;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      prio_q <= 1'b0;
    end else begin
      prio_q <= prio_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Stage 1: capture the granted codeword
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_valid_q <= 1'b0;
      s1_ch_q    <= 1'b0;
      s1_cw_q    <= '0;
    end else if (en) begin
      s1_valid_q <= any_req;
      if (any_req) begin
        s1_ch_q <= grant1;
        s1_cw_q <= grant1 ? in1_codeword : in0_codeword;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Stage 2: reduction by 13
  // ---------------------------------------------------------------------------
  // 78/1024 slightly underestimates 1/13, so q_t is either exact or one short;
  // a single conditional subtract fixes the remainder for every 6-bit input.
  logic [15:0] cw_ext;
  logic [15:0] prod;
  logic [15:0] q_t;
  logic [15:0] q_x13;
  logic [15:0] r_t;
  logic [15:0] q_fix;
  logic [15:0] r_fix;
  logic        unused_bits;

  always_comb begin
    cw_ext = 16'(s1_cw_q);
    prod   = (cw_ext << 1) + (cw_ext << 2) + (cw_ext << 3) + (cw_ext << 6);
    q_t    = prod >> 10;
    q_x13  = q_t + (q_t << 2) + (q_t << 3);
    r_t    = cw_ext - q_x13;
    if (r_t >= 16'd13) begin
      q_fix = q_t + 16'd1;
      r_fix = r_t - 16'd13;
    end else begin
      q_fix = q_t;
      r_fix = r_t;
    end
  end

  // Upper bits are provably zero for 6-bit codewords.
  assign unused_bits = ^{q_fix[15:3], r_fix[15:4]};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_ch    <= 1'b0;
      out_q     <= '0;
      out_r     <= '0;
      out_error <= 1'b0;
    end else if (en) begin
      out_valid <= s1_valid_q;
      // Data only move with a real result so a bubble leaves the last value in place.
      if (s1_valid_q) begin
        out_ch    <= s1_ch_q;
        out_q     <= q_fix[2:0];
        out_r     <= r_fix[3:0];
        out_error <= (r_fix[3:0] != 4'd0);
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Error counters
  // ---------------------------------------------------------------------------
  logic             err_xfer;
  logic [CNT_W-1:0] cnt0_d, cnt1_d;

  assign err_xfer = out_valid && out_ready && out_error;

  always_comb begin
    cnt0_d = err_cnt0;
    cnt1_d = err_cnt1;
    if (clr_cnt) begin
      // Clear wins; a transfer in the same cycle is not counted.
      cnt0_d = '0;
      cnt1_d = '0;
    end else if (err_xfer) begin
      if (!out_ch && (err_cnt0 != {CNT_W{1'b1}})) begin
        cnt0_d = err_cnt0 + 1'b1;
      end
      if (out_ch && (err_cnt1 != {CNT_W{1'b1}})) begin
        cnt1_d = err_cnt1 + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      err_cnt0 <= '0;
      err_cnt1 <= '0;
    end else begin
      err_cnt0 <= cnt0_d;
      err_cnt1 <= cnt1_d;
    end
  end

endmodule

// File: tb/tb_an_decode_rr_sched.sv
// Self-checking bench for an_decode_rr_sched. A cycle-level behavioural model
// (integer div/mod, a two-slot in-flight list, a tie pointer) is compared to
// the DUT on every falling edge; directed literal checks pin the model.

module tb_an_decode_rr_sched;

  localparam int CW_W  = 6;
  localparam int CNT_W = 2;
  localparam int CMAX  = (1 << CNT_W) - 1;

  logic             clk = 1'b0;
  logic             rst = 1'b0;
  logic             in0_valid, in1_valid;
  logic [CW_W-1:0]  in0_codeword, in1_codeword;
  logic             in0_ready, in1_ready;
  logic             out_valid, out_ready;
  logic             out_ch;
  logic [2:0]       out_q;
  logic [3:0]       out_r;
  logic             out_error;
  logic             clr_cnt;
  logic [CNT_W-1:0] err_cnt0, err_cnt1;

  int n_cmp = 0;
  int n_bad = 0;

  an_decode_rr_sched #(
    .CW_W (CW_W),
    .CNT_W(CNT_W)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .in0_valid   (in0_valid),
    .in0_codeword(in0_codeword),
    .in0_ready   (in0_ready),
    .in1_valid   (in1_valid),
    .in1_codeword(in1_codeword),
    .in1_ready   (in1_ready),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_ch      (out_ch),
    .out_q       (out_q),
    .out_r       (out_r),
    .out_error   (out_error),
    .clr_cnt     (clr_cnt),
    .err_cnt0    (err_cnt0),
    .err_cnt1    (err_cnt1)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Behavioural model: one in-flight codeword per stage, results as div/mod.
  // ---------------------------------------------------------------------------
  bit m_s1_v, m_out_v, m_s1_ch, m_out_ch, m_prio;
  int m_s1_cw, m_out_cw;
  int m_cnt[2];

  always @(posedge clk or posedge rst) begin : model
    bit adv, g1, any;
    if (rst) begin
      m_s1_v = 0; m_out_v = 0; m_prio = 0; m_out_ch = 0; m_out_cw = 0;
      m_cnt[0] = 0; m_cnt[1] = 0;
    end else begin
      adv = !m_out_v || out_ready;
      any = in0_valid || in1_valid;
      g1  = in1_valid && (!in0_valid || m_prio);
      if (clr_cnt) begin
        m_cnt[0] = 0; m_cnt[1] = 0;
      end else if (m_out_v && out_ready && (m_out_cw % 13 != 0) && m_cnt[m_out_ch] < CMAX) begin
        m_cnt[m_out_ch] = m_cnt[m_out_ch] + 1;
      end
      if (adv) begin
        if (m_s1_v) begin
          m_out_ch = m_s1_ch;
          m_out_cw = m_s1_cw;
        end
        m_out_v = m_s1_v;
        m_s1_v  = any;
        if (any) begin
          m_s1_ch = g1;
          m_s1_cw = g1 ? int'(in1_codeword) : int'(in0_codeword);
          m_prio  = !g1;
        end
      end
    end
  end

  always @(negedge clk) begin : compare
    bit adv, g1;
    adv = !m_out_v || out_ready;
    g1  = in1_valid && (!in0_valid || m_prio);
    chk("in0_ready", in0_ready, adv && in0_valid && !g1);
    chk("in1_ready", in1_ready, adv && g1);
    chk("out_valid", out_valid, m_out_v);
    if (m_out_v) begin
      chk("out_ch", out_ch, m_out_ch);
      chk("out_q", out_q, m_out_cw / 13);
      chk("out_r", out_r, m_out_cw % 13);
      chk("out_error", out_error, (m_out_cw % 13) != 0);
    end
    chk("err_cnt0", err_cnt0, m_cnt[0]);
    chk("err_cnt1", err_cnt1, m_cnt[1]);
  end

  // ---------------------------------------------------------------------------
  // Directed stimulus
  // ---------------------------------------------------------------------------
  // Offer one codeword for one cycle; its result is visible two edges later.
  task automatic pin(input bit ch, input int cw, input int q, input int r, input int e);
    @(posedge clk); #1;
    if (ch) begin in1_valid = 1; in1_codeword = CW_W'(cw); end
    else    begin in0_valid = 1; in0_codeword = CW_W'(cw); end
    @(posedge clk); #1;
    in0_valid = 0; in1_valid = 0;
    @(posedge clk);
    @(negedge clk);
    chk("pin_valid", out_valid, 1);
    chk("pin_ch", out_ch, ch);
    chk("pin_q", out_q, q);
    chk("pin_r", out_r, r);
    chk("pin_err", out_error, e);
  endtask

  task automatic do_reset();
    @(posedge clk); #1;
    rst = 1;
    @(posedge clk); #1;
    rst = 0;
  endtask

  int sat_exp[5] = '{1, 2, 3, 3, 3};

  initial begin
    in0_valid = 0; in1_valid = 0; in0_codeword = '0; in1_codeword = '0;
    out_ready = 1; clr_cnt = 0;
    #1 rst = 1;
    repeat (2) @(posedge clk);
    #1 rst = 0;
    @(negedge clk);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_q", out_q, 0);
    chk("rst_cnt0", err_cnt0, 0);
    chk("rst_cnt1", err_cnt1, 0);

    // Basic values and the correction path
    pin(0, 27, 2, 1, 1);
    pin(0, 26, 2, 0, 0);
    pin(0, 25, 1, 12, 1);
    pin(0, 39, 3, 0, 0);
    pin(0, 52, 4, 0, 0);
    pin(0, 63, 4, 11, 1);
    pin(1, 40, 3, 1, 1);

    // Back-to-back sweep of every codeword on channel 0
    for (int i = 0; i < 64; i++) begin
      @(posedge clk); #1;
      in0_valid = 1; in0_codeword = CW_W'(i);
    end
    @(posedge clk); #1;
    in0_valid = 0;
    repeat (3) @(posedge clk);

    // Round-robin alternation from a fresh reset
    do_reset();
    in0_valid = 1; in1_valid = 1; in0_codeword = 6'd10; in1_codeword = 6'd20;
    @(negedge clk);
    chk("rr_a0", in0_ready, 1);
    chk("rr_a1", in1_ready, 0);
    @(posedge clk); #1;
    in0_codeword = 6'd11; in1_codeword = 6'd21;
    @(negedge clk);
    chk("rr_b1", in1_ready, 1);
    @(posedge clk); #1;
    in0_codeword = 6'd12; in1_codeword = 6'd22;
    @(negedge clk);
    chk("rr_c0", in0_ready, 1);
    @(posedge clk); #1;
    in1_valid = 0; in0_codeword = 6'd13;
    @(negedge clk);
    chk("rr_d0", in0_ready, 1);
    @(posedge clk); #1;
    in1_valid = 1; in0_codeword = 6'd14; in1_codeword = 6'd23;
    @(negedge clk);
    chk("rr_e1", in1_ready, 1);
    chk("rr_e0", in0_ready, 0);

    // Backpressure with both stages full
    @(posedge clk); #1;
    out_ready = 0; in0_codeword = 6'd33; in1_codeword = 6'd44;
    repeat (3) begin
      @(negedge clk);
      chk("bp_rdy0", in0_ready, 0);
      chk("bp_rdy1", in1_ready, 0);
      @(posedge clk); #1;
    end
    out_ready = 1;
    in0_valid = 0; in1_valid = 0;
    repeat (4) @(posedge clk);

    // Saturation: clear, then five erroring results on channel 1
    #1 clr_cnt = 1;
    @(posedge clk); #1;
    clr_cnt = 0;
    for (int i = 0; i < 5; i++) begin
      pin(1, 1, 0, 1, 1);
      @(posedge clk);
      @(negedge clk);
      chk("sat_cnt1", err_cnt1, sat_exp[i]);
    end

    // Clear coincident with an erroring transfer
    pin(1, 1, 0, 1, 1);
    clr_cnt = 1;
    @(posedge clk); #1;
    clr_cnt = 0;
    @(negedge clk);
    chk("clr_cnt1", err_cnt1, 0);

    // Reset with both stages in flight
    @(posedge clk); #1;
    in0_valid = 1; in1_valid = 1; in0_codeword = 6'd5; in1_codeword = 6'd7;
    repeat (2) @(posedge clk);
    #1 rst = 1;
    #1;
    chk("mid_rst_valid", out_valid, 0);
    chk("mid_rst_cnt0", err_cnt0, 0);
    chk("mid_rst_cnt1", err_cnt1, 0);
    @(negedge clk);
    rst = 0;
    #1;
    chk("post_rst_rdy0", in0_ready, 1);
    chk("post_rst_rdy1", in1_ready, 0);
    @(posedge clk); #1;
    in0_valid = 0; in1_valid = 0;
    repeat (4) @(posedge clk);

    @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/an_decode_rr_sched.md
# an_decode_rr_sched

Two-channel round-robin scheduler around one shared A=13 Barrett-reduction AN-code decoder. Each channel offers 6-bit AN codewords over a valid/ready handshake. The block arbitrates them onto a single two-stage pipelined reduction datapath and returns quotient, remainder, error flag and channel tag on one output stream. It also keeps per-channel saturating error counters, and it sits between the codeword sources and the downstream error-handling logic.

## Interface
Parameters:
- CW_W, 6, codeword width; the datapath is sized for 6 only
- CNT_W, 8, error-counter width

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  reset, asynchronous, active-high
- in0_valid  in  1  channel 0 codeword offered
- in0_codeword  in  CW_W  channel 0 codeword
- in0_ready  out  1  channel 0 codeword accepted this cycle
- in1_valid / in1_codeword / in1_ready  same for channel 1
- out_valid  out  1  result available
- out_ready  in  1  downstream accepts result
- out_ch  out  1  source channel of the result
- out_q  out  3  quotient, codeword div 13
- out_r  out  4  remainder, codeword mod 13
- out_error  out  1  high when out_r != 0
- clr_cnt  in  1  synchronous clear of both counters
- err_cnt0 / err_cnt1  out  CNT_W  saturating error counts per channel

## Operation
- Pipeline enable: en = !out_valid || out_ready. When en is low, every pipeline register holds.
- Arbitration:
  - Happens only when en=1.
  - If exactly one channel is valid, that channel is granted.
  - If both are valid, the channel selected by pointer prio is granted.
  - After any grant, prio is set to the other channel.
  - inX_ready = en && grant==X. It never depends combinationally on out_ready except through en.
- Stage 1 (S1) registers the granted codeword, its channel and s1_valid. s1_valid follows whether a grant occurred.
- Stage 2 (S2) computes from S1 into the output registers:
  - q_t = ((cw<<1)+(cw<<2)+(cw<<3)+(cw<<6))>>10, i.e. (cw*78)>>10, computed 16-bit wide.
  - r_t = cw − 13·q_t, computed as (q_t<<0)+(q_t<<2)+(q_t<<3).
  - If r_t ≥ 13: q = q_t+1 and r = r_t−13. Otherwise q = q_t and r = r_t.
  - At most one correction is ever needed for cw in 0..63.
  - out_error = (r != 0).
  - out_valid follows s1_valid when en=1.
- Error counters:
  - On an output transfer (out_valid && out_ready && out_error), err_cnt[out_ch] increments.
  - A counter at all-ones holds; it does not wrap.
  - clr_cnt has priority over a simultaneous increment. That transfer is not counted.
- A bubble (no request) propagates as a cleared valid. No result is ever duplicated or dropped.

## Timing
- Reset: in0_ready/in1_ready are combinational, 1 for a valid channel when en=1.
  - s1_valid=0, out_valid=0, out_ch=0, out_q=0, out_r=0, out_error=0.
  - prio=0, so channel 0 wins the first tie.
  - err_cnt0=err_cnt1=0.
- Latency: a codeword accepted at edge k appears on the outputs after edge k+1 (2 cycles).
- Throughput: 1 result/cycle while out_ready=1.
- Backpressure: with out_valid=1 and out_ready=0, both readies are 0 and S1, the outputs and prio hold. Output data are stable until the transfer completes.
- Reset asserted mid-operation clears all in-flight results immediately. No counter update occurs for them.

## Test plan
- Channel 0 only, out_ready=1, codewords 27, 26, 25 → after 2 cycles each:
  - 27: q=2 r=1 error=1
  - 26: q=2 r=0 error=0
  - 25: q=1 r=12 error=1
  - out_ch=0 for all.
- Correction path: cw 39 → q=3 r=0 (r_t=13 corrected); cw 52 → q=4 r=0; cw 63 → q=4 r=11. Then sweep all 0..63 and compare against div/mod 13.
- Both channels valid every cycle → grants alternate 0,1,0,1 starting with channel 0, and out_ch alternates accordingly. Dropping in1_valid for one cycle → channel 0 is granted alone and prio flips to 1.
- out_ready low 3 cycles with results in flight → in0_ready=in1_ready=0 and out_* held stable. On release the results drain in order with none lost.
- CNT_W=2, channel 1 sends 5 erroneous codewords (e.g. 1) → err_cnt1 = 1,2,3,3,3. Then clr_cnt asserted on an erroring transfer → err_cnt1=0.
- Assert rst with both pipeline stages valid → out_valid=0 immediately, counters 0. The next tie is granted to channel 0.
